uart_rx_fifo: RTL

- Memory-mapped UART receiver for the CPU's input port, the counterpart of the byte-write output port at 0x082.
- Deserialises 8N1 frames from the `rx` pin and queues the bytes in a small FIFO.
- The CPU reads the FIFO head through the memory decoder at address 0x01e and pops it with a read strobe.
- An empty FIFO reads as 0x00, matching the CPU-visible convention for "no input".

---
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a CPU-readable byte FIFO
module uart_rx_fifo #(
  parameter int CLOCK_HZ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic                          overrun,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int DIV  = CLOCK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state, state_n;
  logic s1, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic push, ferr_set;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic full, do_pop, do_push, ovr_set;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    shift_n  = shift;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: if (cnt == CW'(HALF - 1)) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == CW'(DIV - 1)) begin
        cnt_n        = '0;
        shift_n[idx] = rxs;
        idx_n        = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == CW'(DIV - 1)) begin
        cnt_n    = '0;
        push     = rxs;
        ferr_set = !rxs;
        state_n  = rxs ? IDLE : BRK;
      end
      BRK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign full     = count == (AW + 1)'(FIFO_DEPTH);
  assign do_pop   = rd && count != '0;
  assign do_push  = push && (!full || do_pop);
  assign ovr_set  = push && full && !do_pop;
  assign rx_valid = count != '0;
  assign rd_data  = rx_valid ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1        <= rx;
      rxs       <= s1;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      wr_ptr    <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count     <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
      overrun   <= ovr_set | (overrun & ~clr_err);
      frame_err <= ferr_set | (frame_err & ~clr_err);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= shift;
  end
endmodule
